// File: rtl/data_bus_router.sv
// Data-bus controller: decodes a RAM window and a GPIO register window behind a
// valid/ready request port, steers byte/half/word lanes and returns a single-pulse response.
module data_bus_router #(
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter logic [31:0] GPIO_BASE      = 32'h8000_0000,
  parameter int unsigned GPIO_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  busy,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe
);

  localparam int unsigned RamWords = 2 ** (RAM_ADDR_WIDTH - 2);
  localparam logic [31:0] RamMask  = 32'((64'd1 << RAM_ADDR_WIDTH) - 64'd1);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e state_q, state_d;

  logic                  accept;
  logic                  ram_hit, gpio_hit, misaligned, size_bad, gpio_not_word, err;
  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic [31:0]           gpio_rd;
  logic [31:0]           shifted, load_data;
  logic [RAM_ADDR_WIDTH-3:0] word_idx;

  logic [31:0]           mem [RamWords];
  logic [31:0]           ram_rd_q;
  logic [1:0]            lane_q, size_q;
  logic                  unsigned_q;
  logic                  rsp_err_q;
  logic [31:0]           rsp_rdata_q;
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_oe_q, sync1_q, sync2_q;

  assign req_ready = (state_q == StIdle);
  assign busy      = ~req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign gpio_out  = gpio_out_q;
  assign gpio_oe   = gpio_oe_q;

  // A request arriving together with reset is dropped, never performed.
  assign accept   = req_valid & req_ready & ~rst;
  assign word_idx = req_addr[RAM_ADDR_WIDTH-1:2];

  always_comb begin
    ram_hit       = (req_addr & ~RamMask) == RAM_BASE;
    gpio_hit      = req_addr[31:4] == GPIO_BASE[31:4];
    size_bad      = (req_size == 2'b11);
    misaligned    = (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    gpio_not_word = gpio_hit && (req_size != 2'b10);
    err           = size_bad || !(ram_hit || gpio_hit) || misaligned || gpio_not_word;
  end

  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << req_addr[1:0];
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    gpio_rd = '0;
    case (req_addr[3:2])
      2'b00:   gpio_rd[GPIO_WIDTH-1:0] = gpio_out_q;
      2'b01:   gpio_rd[GPIO_WIDTH-1:0] = gpio_oe_q;
      2'b10:   gpio_rd[GPIO_WIDTH-1:0] = sync2_q;
      default: ;
    endcase
  end

  always_comb begin
    shifted = ram_rd_q >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = (ram_hit && !err && !req_we) ? StRdWait : StResp;
      StRdWait: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // RAM array is not reset; write and synchronous read both happen on the accept edge.
  always_ff @(posedge clk) begin
    if (accept && ram_hit && !err) begin
      if (req_we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end else begin
        ram_rd_q <= mem[word_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lane_q      <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      gpio_out_q  <= '0;
      gpio_oe_q   <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (accept) begin
        lane_q     <= req_addr[1:0];
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        rsp_err_q  <= err;
        if (gpio_hit && !err) begin
          if (req_we) begin
            case (req_addr[3:2])
              2'b00:   gpio_out_q <= req_wdata[GPIO_WIDTH-1:0];
              2'b01:   gpio_oe_q  <= req_wdata[GPIO_WIDTH-1:0];
              default: ;
            endcase
          end else begin
            rsp_rdata_q <= gpio_rd;
          end
        end
      end
      if (state_q == StRdWait) rsp_rdata_q <= load_data;
    end
  end

endmodule

// File: tb/tb_data_bus_router.sv
// Bench for data_bus_router: directed steps then randomized back-to-back traffic, all
// responses compared with a byte-array reference model.
module tb_data_bus_router;

  localparam logic [31:0] GB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem_m [0:4095];
  logic [7:0] gout_m, goe_m;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t q[$];

  data_bus_router dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .busy         (busy),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed from the access rules on a little-endian byte array.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] r, output int lat);
    int   nb;
    logic ram, gp;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ram = a < 32'd4096;
    gp  = a >= GB && a <= GB + 32'd15;
    e   = (sz == 2'd3) || !(ram || gp) || (a % nb != 0) || (gp && sz != 2'd2);
    r   = '0;
    lat = 1;
    if (!e && ram) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
      end else begin
        lat = 2;
        v   = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[int'(a) + i];
        if (!uns && v[8*nb-1]) for (int b = 8 * nb; b < 32; b++) v[b] = 1'b1;
        r = v;
      end
    end else if (!e && gp) begin
      if (we) begin
        if (a[3:0] == 4'h0) gout_m = wd[7:0];
        if (a[3:0] == 4'h4) goe_m  = wd[7:0];
      end else begin
        case (a[3:0])
          4'h0:    r = {24'b0, gout_m};
          4'h4:    r = {24'b0, goe_m};
          4'h8:    r = {24'b0, gpio_in};
          default: r = '0;
        endcase
      end
    end
  endfunction

  task automatic junk();
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic gen();
    int k, s;
    req_we       = 1'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = $urandom;
    s = $urandom_range(0, 9);
    req_size = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
    k = $urandom_range(0, 9);
    if (k < 5)       req_addr = $urandom_range(0, 255);
    else if (k == 5) req_addr = 32'hFF0 + $urandom_range(0, 15);
    else if (k < 8)  req_addr = GB + $urandom_range(0, 15);
    else if (k == 8) req_addr = 32'h1000 + $urandom_range(0, 15);
    else             req_addr = $urandom | 32'h1000_0000;
    if ($urandom_range(0, 1) == 1) begin
      if (req_size == 2'd1) req_addr[0] = 1'b0;
      if (req_size == 2'd2) req_addr[1:0] = 2'b00;
    end
  endtask

  // One request through the port, waiting for acceptance and the response, with bounded waits.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic        e;
    logic [31:0] r;
    int          lat, w, n;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    model(we, sz, uns, a, wd, e, r, lat);
    @(posedge clk); #1;
    req_valid = 1'b0;
    junk();
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_err"}, 32'(rsp_err), 32'(e));
    check({tag, "_rdata"}, rsp_rdata, r);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    rst = 1'b1; req_valid = 1'b0; gpio_in = 8'h00;
    junk();
    gout_m = '0; goe_m = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_gout", 32'(gpio_out), 32'd0);
    check("rst_goe", 32'(gpio_oe), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) do_req("init", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, er);
    for (int i = 1020; i < 1024; i++) do_req("init", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, er);

    // Word store then byte loads, signed and unsigned
    do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
    do_req("lb13s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er);
    check("lb13s_const", rd, 32'hFFFF_FFDE);
    do_req("lb13u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
    check("lb13u_const", rd, 32'h0000_00DE);
    do_req("lh12s", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er);
    check("lh12s_const", rd, 32'hFFFF_DEAD);

    // Half store into upper lane
    do_req("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
    do_req("sh22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_1234, rd, er);
    do_req("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
    check("lw20_const", rd, 32'h1234_0000);
    do_req("lh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd, er);
    check("lh22_const", rd, 32'h0000_1234);

    // Faults: misaligned, illegal size, unmapped; errored store writes nothing
    do_req("e_lh21", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, rd, er);
    check("e_lh21_const", 32'(er), 32'd1);
    do_req("e_lw22", 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, rd, er);
    do_req("e_sz3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, er);
    check("e_sz3_const", 32'(er), 32'd1);
    do_req("e_unmap", 1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'h0, rd, er);
    do_req("e_top", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er);
    do_req("ok_top", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, rd, er);
    do_req("e_sw22", 1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFF_FFFF, rd, er);
    do_req("e_sb4k", 1'b1, 2'd0, 1'b0, 32'h1000_0020, 32'hFF, rd, er);
    do_req("lw20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
    check("lw20b_const", rd, 32'h1234_0000);

    // GPIO registers and synchronised input
    do_req("g_out", 1'b1, 2'd2, 1'b0, GB, 32'h0000_00A5, rd, er);
    check("g_out_pin", 32'(gpio_out), 32'hA5);
    do_req("g_dir", 1'b1, 2'd2, 1'b0, GB + 32'h4, 32'hFFFF_FF0F, rd, er);
    check("g_dir_pin", 32'(gpio_oe), 32'h0F);
    gpio_in = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    do_req("g_in", 1'b0, 2'd2, 1'b0, GB + 32'h8, 32'h0, rd, er);
    check("g_in_const", rd, 32'h3C);
    do_req("g_sb", 1'b1, 2'd0, 1'b0, GB, 32'h11, rd, er);
    check("g_sb_err", 32'(er), 32'd1);
    check("g_sb_pin", 32'(gpio_out), 32'hA5);
    do_req("g_s8", 1'b1, 2'd2, 1'b0, GB + 32'h8, 32'h77, rd, er);
    do_req("g_lC", 1'b0, 2'd2, 1'b0, GB + 32'hC, 32'h0, rd, er);
    do_req("g_l0", 1'b0, 2'd2, 1'b0, GB, 32'h0, rd, er);
    do_req("g_e10", 1'b0, 2'd2, 1'b0, GB + 32'h10, 32'h0, rd, er);

    // Reset while a RAM load sits in RD_WAIT: no response follows
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gout_m = '0; goe_m = '0;
    for (int i = 0; i < 3; i++) begin
      check("mid_norsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("mid_ready", 32'(req_ready), 32'd1);
    check("mid_gout", 32'(gpio_out), 32'd0);
    check("mid_goe", 32'(gpio_oe), 32'd0);

    // Back-to-back traffic with req_valid held high
    gpio_in = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b1;
    gen();
    for (int c = 0; c < 1500; c++) begin
      logic        e;
      logic [31:0] r;
      int          lat;
      exp_t        x;
      check("bb_ready", 32'(req_ready), 32'(q.size() == 0));
      check("bb_busy", 32'(busy), 32'(q.size() != 0));
      check("bb_gout", 32'(gpio_out), 32'(gout_m));
      check("bb_goe", 32'(gpio_oe), 32'(goe_m));
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("bb_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          x = q.pop_front();
          check("bb_due", 32'(c), 32'(x.due));
          check("bb_err", 32'(rsp_err), 32'(x.err));
          check("bb_rdata", rsp_rdata, x.rdata);
        end
      end else if (q.size() != 0 && c > q[0].due) begin
        check("bb_timeout", 32'(rsp_valid), 32'd1);
        void'(q.pop_front());
      end
      if (req_ready) begin
        gen();
        model(req_we, req_size, req_unsigned, req_addr, req_wdata, e, r, lat);
        x.err = e; x.rdata = r; x.due = c + lat;
        q.push_back(x);
      end else begin
        junk();
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4 && q.size() != 0; c++) begin
      if (rsp_valid) begin
        exp_t x;
        x = q.pop_front();
        check("dr_err", 32'(rsp_err), 32'(x.err));
        check("dr_rdata", rsp_rdata, x.rdata);
      end
      @(posedge clk); #1;
    end
    check("dr_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
